param_fifo_buffer: RTL and testbench

- Parametrised multi-entry successor to the single-word load-enable buffer register.
- Stores up to DEPTH words of NUMBITS each in first-in/first-out order, with first-word-fall-through output.
- Provides full/empty/count status and sticky overflow/underflow error flags.
- Sits between producer and consumer stages that run on the same clock, where one stage stalls independently of the other.

---
 rtl/param_fifo_buffer.sv | 114 +++++++++++
 tb/tb_param_fifo_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_fifo_buffer.sv
// param_fifo_buffer: DEPTH x NUMBITS first-word-fall-through FIFO with occupancy
// status and sticky overflow/underflow flags. Define PARAM_FIFO_BUFFER_ALMOST_EN for almost_full/almost_empty.
module param_fifo_buffer #(
    parameter int NUMBITS = 8,
    parameter int DEPTH   = 4,
`ifdef PARAM_FIFO_BUFFER_ALMOST_EN
    parameter int AFULL_LVL  = DEPTH - 1,
    parameter int AEMPTY_LVL = 1,
`endif
    localparam int CNTBITS = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               clear,
    input  logic               push,
    input  logic [NUMBITS-1:0] p_in,
    input  logic               pop,
    output logic [NUMBITS-1:0] p_out,
    output logic               empty,
    output logic               full,
    output logic [CNTBITS-1:0] count,
`ifdef PARAM_FIFO_BUFFER_ALMOST_EN
    output logic               almost_full,
    output logic               almost_empty,
`endif
    output logic               overflow,
    output logic               underflow
);

    localparam int PTRBITS = $clog2(DEPTH);

    logic [NUMBITS-1:0] mem [DEPTH];
    logic [PTRBITS-1:0] wr_ptr, rd_ptr;
    logic [CNTBITS-1:0] count_q;
    logic               overflow_q, underflow_q;

    logic               push_ok, pop_ok;
    logic [PTRBITS-1:0] wr_ptr_d, rd_ptr_d;
    logic [CNTBITS-1:0] count_d;
    logic               overflow_d, underflow_d;

    // Handshake: a push is taken when there is room or a pop frees a slot in the
    // same cycle; a pop is taken whenever a word is stored. Rejections only set flags.
    always_comb begin
        push_ok     = push && (!full || pop);
        pop_ok      = pop && !empty;
        wr_ptr_d    = wr_ptr;
        rd_ptr_d    = rd_ptr;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr + PTRBITS'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr + PTRBITS'(1);
        end

        if (push_ok && !pop_ok) begin
            count_d = count_q + CNTBITS'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNTBITS'(1);
        end

        if (push && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (pop && !pop_ok) begin
            underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst || clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr      <= wr_ptr_d;
            rd_ptr      <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; the head is read combinationally, so a full
    // push+pop reads the old head before the edge overwrites that slot.
    always_ff @(posedge clk) begin
        if (n_rst && !clear && push_ok) begin
            mem[wr_ptr] <= p_in;
        end
    end

    always_comb begin
        empty     = (count_q == '0);
        full      = (count_q == CNTBITS'(DEPTH));
        count     = count_q;
        overflow  = overflow_q;
        underflow = underflow_q;
        p_out     = empty ? '0 : mem[rd_ptr];
    end

`ifdef PARAM_FIFO_BUFFER_ALMOST_EN
    always_comb begin
        almost_full  = (count_q >= CNTBITS'(AFULL_LVL));
        almost_empty = (count_q <= CNTBITS'(AEMPTY_LVL));
    end
`endif

endmodule

// File: tb/tb_param_fifo_buffer.sv
// Directed bench for param_fifo_buffer (NUMBITS=8, DEPTH=4): reset, fill/drain,
// overflow, underflow, pointer wrap, clear and mid-stream reset.
module tb_param_fifo_buffer;

    logic       clk;
    logic       n_rst;
    logic       clear;
    logic       push;
    logic [7:0] p_in;
    logic       pop;
    logic [7:0] p_out;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;
`ifdef PARAM_FIFO_BUFFER_ALMOST_EN
    logic       almost_full;
    logic       almost_empty;
`endif

    int checks = 0;
    int errors = 0;

    param_fifo_buffer #(.NUMBITS(8), .DEPTH(4)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .push         (push),
        .p_in         (p_in),
        .pop          (pop),
        .p_out        (p_out),
        .empty        (empty),
        .full         (full),
        .count        (count),
`ifdef PARAM_FIFO_BUFFER_ALMOST_EN
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
`endif
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge; outputs are sampled and inputs changed 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0;
        pop  = 1'b0;
        clear = 1'b0;
        p_in = 8'h00;
    endtask

    task automatic test_reset();
        n_rst = 1'b0;
        idle();
        step();
        push = 1'b1;
        p_in = 8'hAA;
        step();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
        checks++; if (p_out !== 8'h00) begin errors++; $display("FAIL reset_p_out got %h exp 00", p_out); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b exp 0", overflow); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b exp 0", underflow); end
`ifdef PARAM_FIFO_BUFFER_ALMOST_EN
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost_full got %b exp 0", almost_full); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_almost_empty got %b exp 1", almost_empty); end
`endif
        n_rst = 1'b1;
        idle();
        step();
    endtask

    task automatic fill_11_to_44();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            push = 1'b1;
            p_in = vals[i];
            step();
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
            checks++; if (p_out !== 8'h11) begin errors++; $display("FAIL fill_head[%0d] got %h exp 11", i, p_out); end
        end
        idle();
    endtask

    task automatic test_fill_drain();
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        fill_11_to_44();
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
        checks++; if (empty !== 1'b0) begin errors++; $display("FAIL fill_empty got %b exp 0", empty); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (p_out !== vals[i]) begin errors++; $display("FAIL drain_head[%0d] got %h exp %h", i, p_out, vals[i]); end
            pop = 1'b1;
            step();
        end
        idle();
        checks++; if (p_out !== 8'h00) begin errors++; $display("FAIL drain_p_out got %h exp 00", p_out); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b exp 1", empty); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL drain_count got %0d exp 0", count); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL drain_underflow got %b exp 0", underflow); end
    endtask

    task automatic test_overflow();
        logic [7:0] vals [4];
        vals = '{8'h22, 8'h33, 8'h44, 8'h66};
        fill_11_to_44();
        push = 1'b1;
        p_in = 8'h55;
        step();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL ovf_count got %0d exp 4", count); end
        checks++; if (p_out !== 8'h11) begin errors++; $display("FAIL ovf_head got %h exp 11", p_out); end
        push = 1'b1;
        pop  = 1'b1;
        p_in = 8'h66;
        step();
        idle();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL fullpp_count got %0d exp 4", count); end
        checks++; if (p_out !== 8'h22) begin errors++; $display("FAIL fullpp_head got %h exp 22", p_out); end
        checks++; if (full !== 1'b1) begin errors++; $display("FAIL fullpp_full got %b exp 1", full); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (p_out !== vals[i]) begin errors++; $display("FAIL ovf_drain[%0d] got %h exp %h", i, p_out, vals[i]); end
            pop = 1'b1;
            step();
        end
        idle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drain_empty got %b exp 1", empty); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b exp 1", overflow); end
    endtask

    task automatic test_underflow();
        pop  = 1'b1;
        push = 1'b1;
        p_in = 8'h77;
        step();
        idle();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got %b exp 1", underflow); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL unf_count got %0d exp 1", count); end
        checks++; if (p_out !== 8'h77) begin errors++; $display("FAIL unf_head got %h exp 77", p_out); end
        pop = 1'b1;
        step();
        idle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL unf_pop_empty got %b exp 1", empty); end
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL unf_sticky got %b exp 1", underflow); end
        clear = 1'b1;
        step();
        idle();
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL unf_clear got %b exp 0", underflow); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", overflow); end
    endtask

    task automatic test_wrap();
        push = 1'b1;
        p_in = 8'h00;
        step();
        p_in = 8'h01;
        step();
        for (int d = 2; d < 10; d++) begin
            checks++; if (p_out !== 8'(d - 2)) begin errors++; $display("FAIL wrap_head[%0d] got %h exp %h", d, p_out, 8'(d - 2)); end
            push = 1'b1;
            pop  = 1'b1;
            p_in = 8'(d);
            step();
            checks++; if (count !== 3'd2) begin errors++; $display("FAIL wrap_count[%0d] got %0d exp 2", d, count); end
        end
        idle();
        checks++; if ({overflow, underflow, full, empty} !== 4'b0000) begin errors++; $display("FAIL wrap_flags got %b exp 0000", {overflow, underflow, full, empty}); end
        for (int d = 8; d < 10; d++) begin
            checks++; if (p_out !== 8'(d)) begin errors++; $display("FAIL wrap_tail[%0d] got %h exp %h", d, p_out, 8'(d)); end
            pop = 1'b1;
            step();
        end
        idle();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b exp 1", empty); end
    endtask

    task automatic test_clear();
        fill_11_to_44();
        push = 1'b1;
        p_in = 8'h55;
        step();
        idle();
        pop = 1'b1;
        step();
        idle();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL clr_pre_count got %0d exp 3", count); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL clr_pre_ovf got %b exp 1", overflow); end
`ifdef PARAM_FIFO_BUFFER_ALMOST_EN
        checks++; if (almost_full !== 1'b1) begin errors++; $display("FAIL clr_pre_afull got %b exp 1", almost_full); end
        checks++; if (almost_empty !== 1'b0) begin errors++; $display("FAIL clr_pre_aempty got %b exp 0", almost_empty); end
`endif
        clear = 1'b1;
        push  = 1'b1;
        p_in  = 8'hEE;
        step();
        idle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL clr_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL clr_empty got %b exp 1", empty); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %b exp 0", overflow); end
        checks++; if (p_out !== 8'h00) begin errors++; $display("FAIL clr_p_out got %h exp 00", p_out); end
`ifdef PARAM_FIFO_BUFFER_ALMOST_EN
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL clr_aempty got %b exp 1", almost_empty); end
        checks++; if (almost_full !== 1'b0) begin errors++; $display("FAIL clr_afull got %b exp 0", almost_full); end
`endif
        push = 1'b1;
        p_in = 8'hF0;
        step();
        idle();
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL clr_after_count got %0d exp 1", count); end
        checks++; if (p_out !== 8'hF0) begin errors++; $display("FAIL clr_after_head got %h exp F0", p_out); end
        pop = 1'b1;
        step();
        idle();
    endtask

    task automatic test_midstream_reset();
        push = 1'b1;
        p_in = 8'h3C;
        step();
        p_in = 8'h5A;
        step();
        n_rst = 1'b0;
        p_in = 8'h99;
        pop  = 1'b1;
        step();
        n_rst = 1'b1;
        idle();
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mrst_count got %0d exp 0", count); end
        checks++; if (p_out !== 8'h00) begin errors++; $display("FAIL mrst_p_out got %h exp 00", p_out); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL mrst_underflow got %b exp 0", underflow); end
        step();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL mrst_empty got %b exp 1", empty); end
    endtask

    initial begin
        n_rst = 1'b0;
        idle();
        test_reset();
        test_fill_drain();
        test_overflow();
        test_underflow();
        test_wrap();
        test_clear();
        test_midstream_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
